// File: rtl/yolo_pkg.sv
// yolo_pkg: FP32 constants and the total-order key shared by every pooling stage.
package yolo_pkg;
  localparam int FP32_WIDTH = 32;
  localparam int FP32_SIGN_BIT = 31;
  function automatic logic [FP32_WIDTH-1:0] fp32_key(input logic [FP32_WIDTH-1:0] v);
    return v[FP32_SIGN_BIT] ? ~v : v ^ {1'b1, {(FP32_WIDTH-1){1'b0}}};
  endfunction
endpackage

// File: rtl/fp32_max.sv
// fp32_max: combinational FP32 max under the unsigned-key ordering; ties return a.
module fp32_max
  import yolo_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  assign y = (fp32_key(b) > fp32_key(a)) ? b : a;
endmodule

// File: rtl/layer_2_maxpool2x2.sv
// layer_2_maxpool2x2: streaming 2x2/stride-2 FP32 max-pool over a raster-order frame.
module layer_2_maxpool2x2
  import yolo_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH,
  parameter int IMG_SIZE = 208
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);
  localparam int CW = $clog2(IMG_SIZE);
  localparam int HALF = IMG_SIZE / 2;
  localparam int AW = (HALF > 1) ? $clog2(HALF) : 1;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d, data_out_q, data_out_d;
  logic valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] row_buf_q [HALF];
  logic [DATA_WIDTH-1:0] pm, rd, pool;
  logic [AW-1:0] idx;
  logic last_col, last_row, wr_en, fire;
  fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_col_max (.a(pair_q), .b(data_in), .y(pm));
  fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_row_max (.a(pm), .b(rd), .y(pool));
  always_comb begin
    idx = AW'(col_q >> 1);
    rd = row_buf_q[idx];
    last_col = col_q == CW'(IMG_SIZE - 1);
    last_row = row_q == CW'(IMG_SIZE - 1);
    col_d = valid_in ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d = (valid_in && last_col) ? (last_row ? '0 : row_q + CW'(1)) : row_q;
    pair_d = (valid_in && !col_q[0]) ? data_in : pair_q;
    wr_en = valid_in && col_q[0] && !row_q[0];
    fire = valid_in && col_q[0] && row_q[0];
    data_out_d = fire ? pool : data_out_q;
    valid_out_d = fire;
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q <= '0;
      row_q <= '0;
      pair_q <= '0;
      data_out_q <= '0;
      valid_out_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      pair_q <= pair_d;
      data_out_q <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end
  // Row buffer is always written on an even row before the odd row reads it, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (wr_en) row_buf_q[idx] <= pm;
  end
  assign data_out = data_out_q;
  assign valid_out = valid_out_q;
endmodule

// File: tb/tb_layer_2_maxpool2x2.sv
// tb_layer_2_maxpool2x2: scoreboard bench for a 4x4 instance and a full 208x208 instance.
module tb_layer_2_maxpool2x2;
  typedef struct {logic [31:0] d; int c;} exp_t;
  logic Clk = 1'b0, Rst = 1'b0;
  logic [31:0] s_data_in = '0, b_data_in = '0, s_data_out, b_data_out;
  logic s_valid_in = 1'b0, b_valid_in = 1'b0, s_valid_out, b_valid_out;
  int cyc = 0, n_checks = 0, n_fail = 0, s_pulses = 0, b_pulses = 0;
  exp_t sq[$], bq[$];
  logic [31:0] last_s = '0, last_b = '0;
  logic [31:0] frame_pos [16], frame_neg [16];
  layer_2_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) u_small (
    .Clk(Clk), .Rst(Rst), .data_in(s_data_in), .valid_in(s_valid_in),
    .data_out(s_data_out), .valid_out(s_valid_out));
  layer_2_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(208)) u_big (
    .Clk(Clk), .Rst(Rst), .data_in(b_data_in), .valid_in(b_valid_in),
    .data_out(b_data_out), .valid_out(b_valid_out));
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic logic [31:0] key(input logic [31:0] v);
    return v[31] ? ~v : {1'b1, v[30:0]};
  endfunction
  function automatic logic [31:0] max4(input logic [31:0] a, b, c, d);
    logic [31:0] m;
    m = a;
    if (key(b) > key(m)) m = b;
    if (key(c) > key(m)) m = c;
    if (key(d) > key(m)) m = d;
    return m;
  endfunction
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst) last_s = '0;
    n_checks++;
    if (s_valid_out === 1'b1) begin
      s_pulses++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL small_unexpected_pulse: data_out=%h at cycle %0d, no pulse required", s_data_out, cyc);
      end else begin
        e = sq.pop_front();
        last_s = e.d;
        if (s_data_out !== e.d || cyc !== e.c) begin
          n_fail++;
          $display("FAIL small_pulse: got %h at cycle %0d, required %h at cycle %0d", s_data_out, cyc, e.d, e.c);
        end
      end
    end else if (s_valid_out !== 1'b0 || s_data_out !== last_s) begin
      n_fail++;
      $display("FAIL small_idle_hold: valid_out=%b data_out=%h, required 0 and %h", s_valid_out, s_data_out, last_s);
    end
  end
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst) last_b = '0;
    if (b_valid_out === 1'b1) begin
      b_pulses++;
      n_checks++;
      if (bq.size() == 0) begin
        n_fail++;
        $display("FAIL big_unexpected_pulse: data_out=%h at cycle %0d, no pulse required", b_data_out, cyc);
      end else begin
        e = bq.pop_front();
        last_b = e.d;
        if (b_data_out !== e.d || cyc !== e.c) begin
          n_fail++;
          $display("FAIL big_pulse: got %h at cycle %0d, required %h at cycle %0d", b_data_out, cyc, e.d, e.c);
        end
      end
    end else if (b_valid_out !== 1'b0 || b_data_out !== last_b) begin
      n_checks++;
      n_fail++;
      $display("FAIL big_idle_hold: valid_out=%b data_out=%h, required 0 and %h", b_valid_out, b_data_out, last_b);
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      s_valid_in = 1'b0;
      b_valid_in = 1'b0;
    end
  endtask
  task automatic s_px(input logic [31:0] d, input bit trig, input logic [31:0] e);
    s_valid_in = 1'b1;
    s_data_in = d;
    if (trig) sq.push_back('{e, cyc + 1});
    idle(1);
  endtask
  task automatic s_frame(input logic [31:0] f [16], input logic [31:0] ex [4], input int max_gap);
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      bit trig = ((i / 4) % 2 == 1) && (i % 2 == 1);
      s_px(f[i], trig, trig ? ex[k] : 32'h0);
      if (trig) k++;
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask
  task automatic s_drain(input string name, input int want);
    idle(3);
    n_checks++;
    if (sq.size() != 0 || s_pulses != want) begin
      n_fail++;
      $display("FAIL %s_count: pulses=%0d pending=%0d, required pulses=%0d pending=0", name, s_pulses, sq.size(), want);
    end
    s_pulses = 0;
  endtask
  task automatic test_reset();
    logic [31:0] ex [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      s_valid_in = i[0];
      s_data_in = frame_pos[i + 12];
      @(negedge Clk);
      n_checks++;
      if (s_valid_out !== 1'b0 || s_data_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: valid_out=%b data_out=%h, required 0 and 00000000", s_valid_out, s_data_out);
      end
    end
    @(posedge Clk);
    #1;
    s_valid_in = 1'b0;
    Rst = 1'b1;
    s_pulses = 0;
    idle(1);
    s_frame(frame_pos, ex, 0);
    s_drain("reset_frame", 4);
  endtask
  task automatic test_sign();
    logic [31:0] f [16] = '{
      32'hBF800000, 32'hC0000000, 32'h80000000, 32'h00000000,
      32'hBF000000, 32'hC0400000, 32'hBF800000, 32'hBF800000,
      32'h80000000, 32'h80000000, 32'h3F800000, 32'h80000000,
      32'h80000000, 32'h80000000, 32'hC0000000, 32'h00000000};
    logic [31:0] ex [4] = '{32'hBF000000, 32'h00000000, 32'h80000000, 32'h3F800000};
    s_frame(f, ex, 0);
    s_drain("sign", 4);
  endtask
  task automatic test_gaps();
    logic [31:0] ex [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    s_frame(frame_pos, ex, 5);
    s_drain("gaps", 4);
  endtask
  task automatic test_back_to_back();
    logic [31:0] ex1 [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    logic [31:0] ex2 [4] = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};
    s_frame(frame_pos, ex1, 0);
    s_frame(frame_neg, ex2, 0);
    s_drain("back_to_back", 8);
  endtask
  task automatic test_reset_mid_frame();
    logic [31:0] ex2 [4] = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};
    for (int i = 0; i < 6; i++) s_px(frame_pos[i], i == 5, 32'h40C00000);
    idle(2);
    Rst = 1'b0;
    idle(2);
    Rst = 1'b1;
    s_drain("mid_frame_part", 1);
    s_frame(frame_neg, ex2, 0);
    s_drain("mid_frame_reset", 4);
  endtask
  task automatic test_full_size();
    logic [31:0] prev [208], cur [208];
    b_pulses = 0;
    for (int r = 0; r < 208; r++) begin
      for (int c = 0; c < 208; c++) begin
        cur[c] = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        b_valid_in = 1'b1;
        b_data_in = cur[c];
        if (r[0] && c[0]) bq.push_back('{max4(prev[c-1], prev[c], cur[c-1], cur[c]), cyc + 1});
        idle(1);
      end
      if (!r[0]) prev = cur;
    end
    idle(3);
    n_checks++;
    if (bq.size() != 0 || b_pulses != 10816) begin
      n_fail++;
      $display("FAIL full_size_count: pulses=%0d pending=%0d, required pulses=10816 pending=0", b_pulses, bq.size());
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      frame_pos[i] = i < 1 ? 32'h3F800000 : 32'h0;
    end
    frame_pos = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                  32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                  32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    for (int i = 0; i < 16; i++) frame_neg[i] = frame_pos[i] | 32'h80000000;
    test_reset();
    test_sign();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_full_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/layer_2_maxpool2x2.md
Name: layer_2_maxpool2x2

Overview:
- Downstream stage of each layer-2 feature-map block. Consumes that block's raster-order FP32 pixel stream (IMG_SIZE x IMG_SIZE) after channel summation and activation.
- Performs 2x2 max-pooling with stride 2 and emits an (IMG_SIZE/2) x (IMG_SIZE/2) raster-order FP32 stream into the layer-3 input.
- One instance sits per output feature map.

Parameters:
- DATA_WIDTH, 32, pixel width; IEEE-754 single precision, only 32 supported.
- IMG_SIZE, 208, input frame width and height in pixels; must be even and at least 2.

Ports:
- Clk  input  1  clock, all state on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  input pixel, raster order, row-major.
- valid_in  input  1  data_in is valid this cycle; one pixel consumed per asserted cycle.
- data_out  output  DATA_WIDTH  pooled pixel.
- valid_out  output  1  data_out valid; single-cycle pulse per pooled pixel.

Behaviour:
- Reset state (Rst=0, asynchronous): col_cnt=0, row_cnt=0, pair register=0, data_out=0, valid_out=0.
  - Row buffer contents are don't-care; they are always written before being read.
- Reset mid-frame: the next valid_in after reset release is treated as pixel (0,0).
- Counters and flow control:
  - col_cnt counts 0..IMG_SIZE-1; row_cnt counts 0..IMG_SIZE-1. Both advance only when valid_in=1.
  - col_cnt wraps to 0 and increments row_cnt. After pixel (IMG_SIZE-1, IMG_SIZE-1), both wrap to 0.
  - The next frame follows back-to-back with no gap cycle required.
  - There is no backpressure. Gaps in valid_in of any length are allowed; state holds while valid_in=0.
- Even column (col_cnt[0]=0): latch data_in into the pair register.
- Odd column: pm = fpmax(pair register, data_in).
  - Even row: write pm to row_buf[col_cnt>>1]. The row buffer is IMG_SIZE/2 entries x DATA_WIDTH, one write port and one read port.
  - Odd row: on the same edge, data_out <= fpmax(pm, row_buf[col_cnt>>1]) and valid_out <= 1.
- Latency: valid_out rises exactly 1 cycle after the valid_in of the odd-row, odd-column pixel.
  - valid_out=0 on every other cycle.
  - data_out holds its last value while valid_out=0.
- Output rate: IMG_SIZE/2 pulses per odd input row; (IMG_SIZE/2)^2 pulses per frame.
- Row buffer read must return the value written during the previous (even) row at the same index.
  - Read and write never target the same row in the same cycle: writes occur only on even rows, reads only on odd rows.
  - Read-during-write semantics are therefore irrelevant.
- fpmax(a,b) ordering:
  - Map each operand to a key: if sign=1, key = ~bits; else key = bits ^ 32'h80000000. Compare keys as unsigned and return the operand with the larger key.
  - Ties (bit-identical operands) return a.
  - Consequence: -0 < +0, so fpmax(-0,+0) = +0.
  - NaN and Inf are not produced upstream. No special handling; NaNs order by their bit pattern under the same rule.
- fpmax is combinational. The only pipeline register is on data_out/valid_out, plus the pair register and row buffer.

Decomposition:
- Shared package yolo_pkg:
  - FP32_WIDTH = 32.
  - fp32_sign_bit index constant.
  - fp32 ordering-key function, so layer_3 and later pooling stages reuse it.
- Sub-module fp32_max: purely combinational.
  - Inputs a and b, each DATA_WIDTH; output y.
  - Implements fpmax exactly as above.
  - Instantiated twice: the column pair compare and the row compare.

Test Plan:
- Reset: hold Rst=0 while toggling valid_in -> valid_out=0, data_out=0. Release and send a 4x4 frame (IMG_SIZE=4) of values 1.0..16.0 (3F800000..41800000) -> outputs 6.0, 8.0, 14.0, 16.0 (40C00000, 41000000, 41600000, 41800000), each one cycle after input pixels 5, 7, 13, 15.
- Sign handling: window {-1.0, -2.0, -0.5, -3.0} -> BF000000. Window {-0, +0, -1, -1} (80000000, 00000000, BF800000, BF800000) -> 00000000. Window of all 80000000 -> 80000000.
- Gaps: same 4x4 frame with random 0-5 idle cycles between valid_in pulses -> identical output sequence; each valid_out exactly 1 cycle after the triggering pixel.
- Back-to-back frames: two 4x4 frames, the second with values negated, no gap -> 8 pulses. The second set is -1.0, -3.0, -9.0, -11.0 (BF800000, C0400000, C1100000, C1300000).
- Reset mid-frame: assert Rst after 6 pixels of frame 1, then send a full frame 2 -> only frame-2 results, 4 pulses, no stale row-buffer contribution.
- Full size: IMG_SIZE=208 with random FP32 finite values versus a reference model -> 10816 pulses, bit-exact, 104 per odd row.
